// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared types and defaults for the data_memory_sync slice.
//   - dmem_state_e : init sequencer state (INIT fills storage, READY serves CPU)
//   - DMEM_*       : default parameter values for the memory
//   - even_parity  : even-parity bit over a data word (used when the build
//                    defines DMEM_PARITY_EN)
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } dmem_state_e;

    localparam int         DMEM_DATA_W     = 8;
    localparam int         DMEM_ADDR_W     = 8;
    localparam int         DMEM_DEPTH      = 256;
    localparam logic [7:0] DMEM_INIT_VALUE = 8'h09;

    // Widest word the parity helper accepts; callers zero-extend their data,
    // which leaves the XOR reduction unchanged.
    localparam int DMEM_PARITY_MAX_W = 64;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DMEM_PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dmem_init_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_init_ctrl
//   Init sequencer for data_memory_sync. After reset it walks init_ptr from 0
//   to DEPTH-1, asserting init_we each cycle, then parks in READY until the
//   next reset.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   init_we    out  write strobe for the fill value
//   init_addr  out  address being filled this cycle
//   init_busy  out  sequencer is filling the array
//   ready      out  array is initialised and may accept requests
// -----------------------------------------------------------------------------
module dmem_init_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_busy,
    output logic              ready
);

    // One extra bit so a full-size array (DEPTH = 2**ADDR_W) can step past the
    // last address without wrapping back to zero.
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

    dmem_state_e       state_q, state_d;
    logic [ADDR_W:0]   init_ptr_q, init_ptr_d;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; combinational blocks below use blocking (=).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // Next-state logic.
    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LAST_PTR) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    // Output logic.
    always_comb begin
        init_we   = 1'b0;
        init_busy = 1'b0;
        ready     = 1'b0;
        case (state_q)
            INIT: begin
                init_we   = 1'b1;
                init_busy = 1'b1;
            end
            READY:   ready = 1'b1;
            default: init_busy = 1'b1;
        endcase
    end

    assign init_addr = init_ptr_q[ADDR_W-1:0];

endmodule

// File: rtl/data_memory_sync.sv
// -----------------------------------------------------------------------------
// data_memory_sync
//   CPU data memory: synchronous write, registered read (1-cycle latency),
//   valid/ready request handshake, hardware fill with INIT_VALUE after reset.
//   Out-of-range reads return 0 with rsp_err=1; out-of-range writes are dropped.
//
//   Build option DMEM_PARITY_EN: each word carries an even-parity bit, and a
//   parity mismatch on read raises rsp_err alongside the stored data.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle when high
//   req_write  in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle pulse, read response valid
//   rsp_rdata  out  read data (holds when rsp_valid=0)
//   rsp_err    out  out-of-range (or parity) error, qualified by rsp_valid
//   init_busy  out  init sequencer running
// -----------------------------------------------------------------------------
module data_memory_sync
    import dmem_pkg::*;
#(
    parameter int                DATA_W     = DMEM_DATA_W,
    parameter int                ADDR_W     = DMEM_ADDR_W,
    parameter int                DEPTH      = DMEM_DEPTH,
    parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(DMEM_INIT_VALUE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

`ifdef DMEM_PARITY_EN
    localparam int STORE_W = DATA_W + 1;
`else
    localparam int STORE_W = DATA_W;
`endif

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic               init_we;
    logic [ADDR_W-1:0]  init_addr;
    logic               acc;
    logic               in_range;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_data;
    logic [STORE_W-1:0] mem_word;
    logic [STORE_W-1:0] rd_word;
    logic               parity_err;

    logic [STORE_W-1:0] mem [DEPTH];

    dmem_init_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_init_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_busy (init_busy),
        .ready     (req_ready)
    );

    assign acc      = req_valid && req_ready;
    // Zero-extended so the compare is unsigned and DEPTH = 2**ADDR_W fits.
    assign in_range = ({1'b0, req_addr} < DEPTH_L);

    // Write-port mux: the sequencer owns the array during INIT (req_ready is
    // low then, so requests cannot collide). Nothing commits on a reset edge.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = req_addr;
        mem_data = req_wdata;
        if (init_we) begin
            mem_we   = 1'b1;
            mem_addr = init_addr;
            mem_data = INIT_VALUE;
        end else if (acc && req_write && in_range) begin
            mem_we = 1'b1;
        end
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

`ifdef DMEM_PARITY_EN
    assign mem_word   = {even_parity(DMEM_PARITY_MAX_W'(mem_data)), mem_data};
    // Stored word including its parity bit must reduce to zero.
    assign parity_err = ^rd_word;
`else
    assign mem_word   = mem_data;
    assign parity_err = 1'b0;
`endif

    // NOTE: the storage array has no reset; the init sequencer fills it, which
    // keeps it mappable onto RAM macros.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[IDX_W-1:0]] <= mem_word;
        end
    end

    assign rd_word = in_range ? mem[req_addr[IDX_W-1:0]] : '0;

    // Registered read response. Data and error only update on an accepted
    // read, so rsp_rdata holds between responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= acc && !req_write;
            if (acc && !req_write) begin
                if (in_range) begin
                    rsp_rdata <= rd_word[DATA_W-1:0];
                    rsp_err   <= parity_err;
                end else begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_sync.sv
// -----------------------------------------------------------------------------
// tb_data_memory_sync
//   Two instances share one stimulus stream: d0 with default parameters and
//   d1 with DEPTH=200 (addresses >= 0xC8 out of range). The driver pushes the
//   hand-computed response for each read into a per-instance queue together
//   with the negedge on which it must appear; a monitor on the falling edge
//   pops and compares whenever rsp_valid is seen.
// -----------------------------------------------------------------------------
module tb_data_memory_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;

    logic       req_ready0, rsp_valid0, rsp_err0, init_busy0;
    logic [7:0] rsp_rdata0;
    logic       req_ready1, rsp_valid1, rsp_err1, init_busy1;
    logic [7:0] rsp_rdata1;

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   ncnt  = 0;

    always #5 clk = ~clk;

    data_memory_sync dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready0),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid0),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0),
        .init_busy (init_busy0)
    );

    data_memory_sync #(.DEPTH(200)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready1),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid1),
        .rsp_rdata (rsp_rdata1),
        .rsp_err   (rsp_err1),
        .init_busy (init_busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares responses as they appear, and flags a missing one
    // once its due negedge has passed.
    always @(negedge clk) begin : monitor
        exp_t e;
        ncnt++;
        if (rsp_valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                check("d0_unexpected_rsp", 32'(rsp_valid0), 0);
            end else begin
                e = q0.pop_front();
                check("d0_rsp_cycle", ncnt, e.due);
                check("d0_rdata", 32'(rsp_rdata0), 32'(e.data));
                check("d0_err", 32'(rsp_err0), 32'(e.err));
            end
        end else if (q0.size() > 0 && q0[0].due <= ncnt) begin
            e = q0.pop_front();
            check("d0_rsp_valid", 32'(rsp_valid0), 1);
        end
        if (rsp_valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("d1_unexpected_rsp", 32'(rsp_valid1), 0);
            end else begin
                e = q1.pop_front();
                check("d1_rsp_cycle", ncnt, e.due);
                check("d1_rdata", 32'(rsp_rdata1), 32'(e.data));
                check("d1_err", 32'(rsp_err1), 32'(e.err));
            end
        end else if (q1.size() > 0 && q1[0].due <= ncnt) begin
            e = q1.pop_front();
            check("d1_rsp_valid", 32'(rsp_valid1), 1);
        end
    end

    // Driven at posedge+1: the request is accepted on the next posedge and the
    // response is sampled on the negedge after that, i.e. two negedges later.
    task automatic rd(input logic [7:0] a, input logic [7:0] d0, input logic e0,
                      input logic [7:0] d1, input logic e1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        req_wdata = 8'h00;
        q0.push_back('{due: ncnt + 2, data: d0, err: e0});
        q1.push_back('{due: ncnt + 2, data: d1, err: e1});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    // One reset edge, then check every reset value.
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_req_ready0", 32'(req_ready0), 0);
        check("rst_init_busy0", 32'(init_busy0), 1);
        check("rst_rsp_valid0", 32'(rsp_valid0), 0);
        check("rst_rsp_rdata0", 32'(rsp_rdata0), 0);
        check("rst_rsp_err0", 32'(rsp_err0), 0);
        check("rst_req_ready1", 32'(req_ready1), 0);
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    // Count edges from reset release until req_ready rises. With poke set, a
    // write of 0xEE to 0x30 and then a read are offered mid-INIT (ptr ~100);
    // both must be ignored.
    task automatic measure_init(input bit poke);
        int n        = 0;
        int c0       = 0;
        int c1       = 0;
        int mismatch = 0;
        while ((c0 == 0 || c1 == 0) && n < 400) begin
            if (poke && n == 100) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = 8'h30;
                req_wdata = 8'hEE;
            end
            if (poke && n == 102) req_write = 1'b0;
            if (poke && n == 104) req_valid = 1'b0;
            @(posedge clk); #1;
            n++;
            if (init_busy0 === req_ready0) mismatch++;
            if (req_ready0 === 1'b1 && c0 == 0) c0 = n;
            if (req_ready1 === 1'b1 && c1 == 0) c1 = n;
        end
        req_valid = 1'b0;
        req_write = 1'b0;
        check("init_cycles_d0", c0, 256);
        check("init_cycles_d1", c1, 200);
        check("init_busy_vs_ready", mismatch, 0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        measure_init(1'b1);

        // Fill value everywhere; 0xFF is out of range for d1; 0x30 untouched
        // by the writes offered during INIT.
        rd(8'h00, 8'h09, 1'b0, 8'h09, 1'b0);
        rd(8'h7F, 8'h09, 1'b0, 8'h09, 1'b0);
        rd(8'hFF, 8'h09, 1'b0, 8'h00, 1'b1);
        rd(8'h30, 8'h09, 1'b0, 8'h09, 1'b0);

        // Write-then-read ordering, neighbour unaffected, data hold.
        wr(8'h10, 8'hA5);
        rd(8'h10, 8'hA5, 1'b0, 8'hA5, 1'b0);
        rd(8'h11, 8'h09, 1'b0, 8'h09, 1'b0);
        rd(8'h10, 8'hA5, 1'b0, 8'hA5, 1'b0);
        idle_cycle();
        idle_cycle();
        check("rdata_hold", 32'(rsp_rdata0), 32'h A5);
        check("valid_low_idle", 32'(rsp_valid0), 0);

        // Back-to-back reads return in order.
        wr(8'h01, 8'h11);
        wr(8'h02, 8'h22);
        wr(8'h03, 8'h33);
        rd(8'h01, 8'h11, 1'b0, 8'h11, 1'b0);
        rd(8'h02, 8'h22, 1'b0, 8'h22, 1'b0);
        rd(8'h03, 8'h33, 1'b0, 8'h33, 1'b0);

        // Boundary: 0xC8 is the first out-of-range word of d1.
        wr(8'hC8, 8'h55);
        rd(8'hC8, 8'h55, 1'b0, 8'h00, 1'b1);
        rd(8'hC7, 8'h09, 1'b0, 8'h09, 1'b0);

        // Reset in READY with a read on the reset edge: no response, re-init.
        wr(8'h20, 8'h3C);
        rd(8'h20, 8'h3C, 1'b0, 8'h3C, 1'b0);
        idle_cycle();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h20;
        do_reset();
        measure_init(1'b0);
        rd(8'h20, 8'h09, 1'b0, 8'h09, 1'b0);

        // Reset mid-INIT (ptr=100): init restarts and takes the full depth.
        do_reset();
        repeat (100) idle_cycle();
        do_reset();
        measure_init(1'b0);
        rd(8'hC8, 8'h09, 1'b0, 8'h00, 1'b1);

`ifdef DMEM_PARITY_EN
        // Corrupt the stored parity bit of 0x05, then repair it via a write.
        wr(8'h05, 8'h0F);
        dut0.mem[5][8] = ~dut0.mem[5][8];
        dut1.mem[5][8] = ~dut1.mem[5][8];
        rd(8'h05, 8'h0F, 1'b1, 8'h0F, 1'b1);
        wr(8'h05, 8'h0F);
        rd(8'h05, 8'h0F, 1'b0, 8'h0F, 1'b0);
`endif

        repeat (3) idle_cycle();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_sync.md
Name: data_memory_sync

Overview:
Next-generation CPU data memory with parametrised width and depth.
- Synchronous write; registered read with 1-cycle latency.
- Valid/ready request handshake.
- Hardware init sequencer fills every word with INIT_VALUE after reset, instead of relying on simulation-only initialisation.
- Sits between the CPU load/store stage and storage; out-of-range accesses are flagged on the response.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 8, address width in bits
DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
INIT_VALUE, 8'h09, value written to every word by the init sequencer (DATA_W bits)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle pulse, read data valid
rsp_rdata  output  DATA_W  read data
rsp_err  output  1  error qualifier, valid with rsp_valid
init_busy  output  1  init sequencer running

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values (clock edge with rst_n=0):
  - state=INIT, init_ptr=0, init_busy=1, req_ready=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Storage array is not reset directly.
- State INIT:
  - Each cycle writes INIT_VALUE to mem[init_ptr], then init_ptr++.
  - After the write to DEPTH-1: state=READY, init_busy=0, req_ready=1 on the next edge.
  - Init takes exactly DEPTH cycles after rst_n rises.
  - req_valid is ignored while in INIT.
- State READY:
  - req_ready=1 constantly.
  - Transfer occurs when req_valid && req_ready.
  - Only reset leaves READY.
- Write transfer:
  - mem[req_addr] updated at that edge.
  - No response; rsp_valid stays 0.
- Read transfer:
  - Next cycle: rsp_valid=1, rsp_rdata=mem[req_addr], rsp_err=0.
  - rsp_valid deasserts the following cycle unless another read is accepted.
  - Back-to-back reads produce back-to-back responses.
- Read in cycle N+1 of a write accepted in cycle N returns the new data (write-then-read ordering).
- Out of range (req_addr >= DEPTH):
  - Write is dropped; memory is unchanged.
  - Read responds with rsp_rdata=0, rsp_err=1.
  - Only possible when DEPTH < 2**ADDR_W.
- rsp_rdata holds its last value when rsp_valid=0.
- Reset mid-INIT or mid-READY:
  - Restarts INIT from address 0.
  - Any pending response is cancelled (rsp_valid=0 at the reset edge).
- Width rules:
  - init_ptr is ADDR_W+1 bits so DEPTH = 2**ADDR_W terminates without wrap.
  - Address compare is unsigned.

Optional Feature:
DMEM_PARITY_EN
- Defined:
  - Each word is stored as DATA_W+1 bits with an even-parity bit computed on write and on init.
  - On read, a parity mismatch sets rsp_err=1; rsp_rdata still carries the stored data bits.
  - rsp_err = out_of_range | parity_error.
- Undefined:
  - Storage is DATA_W bits.
  - rsp_err reflects out-of-range only.
- Port list is identical in both builds.

Decomposition:
- Package dmem_pkg holds:
  - state enum {INIT, READY}
  - default constants DMEM_DATA_W=8, DMEM_ADDR_W=8, DMEM_DEPTH=256, DMEM_INIT_VALUE=8'h09
  - parity function (even parity over DATA_W)
- Sub-module dmem_init_ctrl:
  - Contains the init_ptr counter and state FSM.
  - Outputs init_we, init_addr, init_busy, ready.
  - The top level muxes init vs request write ports into the array.

Test Plan:
- Reset then release, default params -> req_ready=0 and init_busy=1 for 256 cycles, then req_ready=1; read addr 0x00, 0x7F, 0xFF -> rsp_rdata=0x09 each, rsp_err=0, 1-cycle latency.
- Write 0xA5 @0x10, read 0x10 next cycle -> rsp_valid one cycle later with 0xA5; read 0x11 -> 0x09.
- Reads at 0x01, 0x02, 0x03 on consecutive cycles -> three consecutive rsp_valid pulses, data in order; req_valid while INIT -> no rsp_valid, memory unchanged.
- DEPTH=200: write 0x55 @0xC8 then read 0xC8 -> rsp_rdata=0x00, rsp_err=1; read 0xC7 -> 0x09, rsp_err=0.
- Write 0x3C @0x20, assert rst_n=0 for 1 cycle mid-stream (incl. mid-INIT at ptr=100) -> rsp_valid=0, init restarts at 0, takes full DEPTH cycles; read 0x20 -> 0x09.
- DMEM_PARITY_EN: write 0x0F @0x05, force the stored parity bit flipped, read 0x05 -> rsp_rdata=0x0F, rsp_err=1; unforced read -> rsp_err=0.
